// File: rtl/spi_controller_pkg.sv
// Shared types and helpers for the SPI primary controller.
package spi_types;

  typedef enum logic [2:0] {
    WRITE_8         = 3'd0,
    WRITE_16        = 3'd1,
    WRITE_8_READ_8  = 3'd2,
    WRITE_8_READ_16 = 3'd3,
    WRITE_8_READ_24 = 3'd4
  } spi_transaction_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TX,
    S_RX,
    S_DONE
  } spi_state_t;

  localparam int unsigned RX_W = 24;

  function automatic logic [4:0] tx_bits(input spi_transaction_t mode);
    return (mode == WRITE_16) ? 5'd16 : 5'd8;
  endfunction

  // Undefined encodings fall through to a plain 8-bit write with no read-back.
  function automatic logic [4:0] rx_bits(input spi_transaction_t mode);
    case (mode)
      WRITE_8_READ_8:  return 5'd8;
      WRITE_8_READ_16: return 5'd16;
      WRITE_8_READ_24: return 5'd24;
      default:         return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_controller_sclk_gen.sv
// sclk generator: half-period down-counter with registered sclk and
// single-cycle strobes marking the clk edge that raises or lowers sclk.
module spi_controller_sclk_gen #(
  parameter int unsigned HALF_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tc;

  assign tc   = en && (cnt_q == '0);
  assign rise = tc && !sclk_q;
  assign fall = tc && sclk_q;
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = RELOAD;
      sclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = RELOAD;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RELOAD;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 primary: 8/16-bit writes, plus 8/16/24-bit read-back when
// SPI_READ_WRITE_EN is defined (otherwise read modes act as WRITE_8).
//   state  | meaning
//   S_IDLE | csb high, ready for a command
//   S_TX   | shifting command bits out on mosi
//   S_RX   | shifting response bits in from miso
//   S_DONE | response held on o_data until o_ready
module spi_controller
  import spi_types::*;
#(
  parameter int unsigned SCLK_HALF_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             sclk,
  output logic             csb,
  output logic             mosi,
  input  logic             miso,
  input  spi_transaction_t spi_mode,
  output logic             i_ready,
  input  logic             i_valid,
  input  logic [15:0]      i_data,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [23:0]      o_data
);

  spi_state_t  state_q, state_d;
  logic        csb_q, csb_d;
  logic        mosi_q, mosi_d;
  logic [15:0] tx_sh_q, tx_sh_d;
  logic [4:0]  bits_q, bits_d;
  logic        sclk_en, sclk_rise, sclk_fall;

`ifdef SPI_READ_WRITE_EN
  logic [RX_W-1:0] rx_sh_q, rx_sh_d;
  logic [4:0]      rx_len_q, rx_len_d;
  logic            o_valid_q, o_valid_d;
  logic [23:0]     o_data_q, o_data_d;
`endif

  assign sclk_en = (state_q == S_TX) || (state_q == S_RX);

  spi_controller_sclk_gen #(
    .HALF_CYCLES(SCLK_HALF_CYCLES)
  ) u_sclk_gen (
    .clk (clk),
    .rst (rst),
    .en  (sclk_en),
    .sclk(sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  always_comb begin
    state_d = state_q;
    csb_d   = csb_q;
    mosi_d  = mosi_q;
    tx_sh_d = tx_sh_q;
    bits_d  = bits_q;
`ifdef SPI_READ_WRITE_EN
    rx_sh_d   = rx_sh_q;
    rx_len_d  = rx_len_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          // 8-bit commands are left-aligned so the shifter always emits bit 15
          tx_sh_d = (spi_mode == WRITE_16) ? i_data : {i_data[7:0], 8'h00};
          mosi_d  = (spi_mode == WRITE_16) ? i_data[15] : i_data[7];
          bits_d  = tx_bits(spi_mode) - 5'd1;
          csb_d   = 1'b0;
          state_d = S_TX;
`ifdef SPI_READ_WRITE_EN
          rx_len_d = rx_bits(spi_mode);
          rx_sh_d  = '0;
`endif
        end
      end
      S_TX: begin
        if (sclk_fall) begin
          if (bits_q == '0) begin
            mosi_d = 1'b0;
`ifdef SPI_READ_WRITE_EN
            if (rx_len_q != '0) begin
              bits_d  = rx_len_q - 5'd1;
              state_d = S_RX;
            end else begin
              csb_d   = 1'b1;
              state_d = S_IDLE;
            end
`else
            csb_d   = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            bits_d  = bits_q - 5'd1;
            tx_sh_d = {tx_sh_q[14:0], 1'b0};
            mosi_d  = tx_sh_q[14];
          end
        end
      end
`ifdef SPI_READ_WRITE_EN
      S_RX: begin
        if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[RX_W-2:0], miso};
        end
        if (sclk_fall) begin
          if (bits_q == '0) begin
            csb_d     = 1'b1;
            o_valid_d = 1'b1;
            o_data_d  = rx_sh_q;
            state_d   = S_DONE;
          end else begin
            bits_d = bits_q - 5'd1;
          end
        end
      end
      S_DONE: begin
        if (o_ready) begin
          o_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      csb_q   <= 1'b1;
      mosi_q  <= 1'b0;
      tx_sh_q <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      mosi_q  <= mosi_d;
      tx_sh_q <= tx_sh_d;
      bits_q  <= bits_d;
    end
  end

`ifdef SPI_READ_WRITE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh_q   <= '0;
      rx_len_q  <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_len_q  <= rx_len_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
`else
  logic unused_rx;
  assign unused_rx = ^{miso, o_ready, sclk_rise};
  assign o_valid   = 1'b0;
  assign o_data    = '0;
`endif

  assign csb     = csb_q;
  assign mosi    = mosi_q;
  assign i_ready = (state_q == S_IDLE) && !rst;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a peripheral model captures mosi and
// drives miso; expectations are queued at stimulus and compared on completion.
module tb_spi_controller;
  import spi_types::*;

  localparam int H = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             miso = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready = 1'b1;
  logic [15:0]      i_data = '0;
  spi_transaction_t spi_mode = WRITE_8;
  logic             sclk, csb, mosi, i_ready, o_valid;
  logic [23:0]      o_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_cap_q[$], obs_cap_q[$];
  int          exp_bits_q[$], obs_bits_q[$];
  int          exp_csb_q[$], obs_csb_q[$];
  logic [23:0] exp_rsp_q[$], obs_rsp_q[$];

  int          per_ntx = 8, per_nrx = 0;
  logic [23:0] per_resp = '0;
  int          csb_low = 0, mon_bits = 0, fall_cnt = 0, done_cnt = 0, valid_cnt = 0, idx;
  logic        csb_prev = 1'b1, sclk_prev = 1'b0;
  logic [31:0] cap = '0;

  always #5 clk = ~clk;

  spi_controller #(.SCLK_HALF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso),
    .spi_mode(spi_mode), .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data)
  );

  // Peripheral + monitor: samples mosi after sclk rises, shifts miso after sclk falls.
  always @(negedge clk) begin
    if (csb === 1'b0) begin
      csb_low++;
      if (sclk === 1'b1 && !sclk_prev) begin
        cap = {cap[30:0], mosi};
        mon_bits++;
      end
      if (sclk === 1'b0 && sclk_prev) fall_cnt++;
    end else begin
      if (csb_prev === 1'b0) begin
        obs_cap_q.push_back(cap);
        obs_bits_q.push_back(mon_bits);
        obs_csb_q.push_back(csb_low);
        done_cnt++;
      end
      csb_low = 0; cap = '0; mon_bits = 0; fall_cnt = 0;
    end
    csb_prev  = csb;
    sclk_prev = sclk;
    idx  = fall_cnt - per_ntx;
    miso = (csb === 1'b0 && idx >= 0 && idx < per_nrx) ? per_resp[per_nrx-1-idx] : 1'b0;
    if (o_valid === 1'b1) valid_cnt++;
    if (o_valid === 1'b1 && o_ready) obs_rsp_q.push_back(o_data);
  end

  function automatic int model_ntx(input logic [2:0] m);
    return (m == 3'd1) ? 16 : 8;
  endfunction

  function automatic int model_nrx(input logic [2:0] m);
`ifdef SPI_READ_WRITE_EN
    case (m)
      3'd2:    return 8;
      3'd3:    return 16;
      3'd4:    return 24;
      default: return 0;
    endcase
`else
    return (m == 3'd7) ? 0 : 0 * int'(m);
`endif
  endfunction

  function automatic logic [23:0] model_resp(input logic [2:0] m, input int i);
    case (m)
      3'd2:    return 24'((256 - i) & 8'hFF);
      3'd3:    return 24'(i * i);
      default: return 24'(i * i * i);
    endcase
  endfunction

  task automatic run_xfer(input logic [2:0] mode, input logic [15:0] data, input logic [23:0] resp);
    int ntx, nrx, n, start;
    logic [31:0] tx;
    ntx = model_ntx(mode);
    nrx = model_nrx(mode);
    tx  = (ntx == 16) ? {16'h0, data} : {24'h0, data[7:0]};
    exp_cap_q.push_back(tx << nrx);
    exp_bits_q.push_back(ntx + nrx);
    exp_csb_q.push_back(2 * H * (ntx + nrx));
    per_ntx = ntx; per_nrx = nrx; per_resp = resp;
    n = 0;
    while (i_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    start    = done_cnt;
    i_valid  = 1'b1;
    i_data   = data;
    spi_mode = spi_transaction_t'(mode);
    @(posedge clk); #1;
    i_valid  = 1'b0;
    i_data   = 16'($urandom);
    spi_mode = spi_transaction_t'($urandom_range(0, 7));
    n = 0;
    while (done_cnt == start && n < 4000) begin @(posedge clk); #1; n++; end
    if (done_cnt == start) begin
      obs_cap_q.push_back('1);
      obs_bits_q.push_back(-1);
      obs_csb_q.push_back(-1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sclk, csb, mosi, o_valid, i_ready} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_outputs: sclk,csb,mosi,o_valid,i_ready got %b want 01000",
               {sclk, csb, mosi, o_valid, i_ready});
    end
    checks++;
    if (o_data !== 24'h0) begin
      failures++;
      $display("FAIL reset_o_data: got %h want 000000", o_data);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_i_ready: got %b want 1", i_ready);
    end
  endtask

  task automatic test_write(input logic [2:0] mode, input logic [15:0] base);
    logic [31:0] ec, oc;
    int eb, ob, ecs, ocs;
    for (int i = 0; i < 4; i++) begin
      run_xfer(mode, base + 16'(i), 24'h0);
      ec = exp_cap_q.pop_front();  oc = obs_cap_q.pop_front();
      eb = exp_bits_q.pop_front(); ob = obs_bits_q.pop_front();
      ecs = exp_csb_q.pop_front(); ocs = obs_csb_q.pop_front();
      checks++;
      if (oc !== ec) begin
        failures++;
        $display("FAIL write_m%0d_mosi[%0d]: got %h want %h", mode, i, oc, ec);
      end
      checks++;
      if (ob !== eb) begin
        failures++;
        $display("FAIL write_m%0d_bits[%0d]: got %0d want %0d", mode, i, ob, eb);
      end
      checks++;
      if (ocs !== ecs) begin
        failures++;
        $display("FAIL write_m%0d_csb_cycles[%0d]: got %0d want %0d", mode, i, ocs, ecs);
      end
      checks++;
      if (i_ready !== 1'b1) begin
        failures++;
        $display("FAIL write_m%0d_i_ready[%0d]: got %b want 1", mode, i, i_ready);
      end
    end
    checks++;
    if (valid_cnt !== 0) begin
      failures++;
      $display("FAIL write_m%0d_no_o_valid: got %0d valid cycles want 0", mode, valid_cnt);
    end
  endtask

  task automatic test_read(input logic [2:0] mode);
    logic [31:0] ec, oc;
    logic [23:0] resp, er, orr;
    int ecs, ocs, n;
    for (int i = 1; i <= 10; i++) begin
      resp = model_resp(mode, i);
`ifdef SPI_READ_WRITE_EN
      exp_rsp_q.push_back(resp);
`endif
      run_xfer(mode, 16'(i), resp);
      ec = exp_cap_q.pop_front();  oc = obs_cap_q.pop_front();
      ecs = exp_csb_q.pop_front(); ocs = obs_csb_q.pop_front();
      void'(exp_bits_q.pop_front());
      void'(obs_bits_q.pop_front());
      checks++;
      if (oc !== ec || ocs !== ecs) begin
        failures++;
        $display("FAIL read_m%0d_frame[%0d]: mosi %h csb %0d want mosi %h csb %0d",
                 mode, i, oc, ocs, ec, ecs);
      end
`ifdef SPI_READ_WRITE_EN
      n = 0;
      while (obs_rsp_q.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
      er = exp_rsp_q.pop_front();
      checks++;
      if (obs_rsp_q.size() == 0) begin
        failures++;
        $display("FAIL read_m%0d_resp[%0d]: no response want %h", mode, i, er);
      end else begin
        orr = obs_rsp_q.pop_front();
        if (orr !== er) begin
          failures++;
          $display("FAIL read_m%0d_resp[%0d]: got %h want %h", mode, i, orr, er);
        end
      end
`else
      n = 0; er = 24'h0; orr = o_data;
      checks++;
      if (valid_cnt !== n || orr !== er) begin
        failures++;
        $display("FAIL read_m%0d_disabled[%0d]: valid cycles %0d o_data %h want 0 and 000000",
                 mode, i, valid_cnt, orr);
      end
`endif
    end
  endtask

  task automatic test_hold();
    int ecs, ocs;
    logic [23:0] orr;
    o_ready = 1'b0;
    run_xfer(3'd4, 16'd10, 24'd1000);
    ecs = exp_csb_q.pop_front(); ocs = obs_csb_q.pop_front();
    void'(exp_cap_q.pop_front());  void'(obs_cap_q.pop_front());
    void'(exp_bits_q.pop_front()); void'(obs_bits_q.pop_front());
    checks++;
    if (ocs !== ecs) begin
      failures++;
      $display("FAIL hold_csb_cycles: got %0d want %0d", ocs, ecs);
    end
`ifdef SPI_READ_WRITE_EN
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 24'd1000 || i_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stall[%0d]: o_valid %b o_data %h i_ready %b want 1 0003e8 0",
                 k, o_valid, o_data, i_ready);
      end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 24'd1000 || i_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: o_valid %b o_data %h i_ready %b want 0 0003e8 1",
               o_valid, o_data, i_ready);
    end
    checks++;
    orr = (obs_rsp_q.size() != 0) ? obs_rsp_q.pop_front() : 24'hxxxxxx;
    if (obs_rsp_q.size() != 0 || orr !== 24'd1000) begin
      failures++;
      $display("FAIL hold_resp: got %h (extra %0d) want 0003e8", orr, obs_rsp_q.size());
    end
`else
    for (int k = 0; k < 5; k++) begin
      orr = o_data;
      checks++;
      if (o_valid !== 1'b0 || orr !== 24'h0 || i_ready !== 1'b1) begin
        failures++;
        $display("FAIL hold_disabled[%0d]: o_valid %b o_data %h i_ready %b want 0 000000 1",
                 k, o_valid, orr, i_ready);
      end
      @(posedge clk); #1;
    end
`endif
    o_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n, ocs, ecs;
    logic [31:0] oc, ec;
    n = 0;
    while (i_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    i_valid = 1'b1; i_data = 16'h55AA; spi_mode = WRITE_16;
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 0;
    while (mon_bits < 3 && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({csb, sclk, mosi, o_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_mid_outputs: csb,sclk,mosi,o_valid got %b want 1000",
               {csb, sclk, mosi, o_valid});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    obs_cap_q.delete(); obs_bits_q.delete(); obs_csb_q.delete();
    run_xfer(3'd0, 16'h00AA, 24'h0);
    ec = exp_cap_q.pop_front();  oc = obs_cap_q.pop_front();
    ecs = exp_csb_q.pop_front(); ocs = obs_csb_q.pop_front();
    void'(exp_bits_q.pop_front()); void'(obs_bits_q.pop_front());
    checks++;
    if (oc !== ec || ocs !== ecs) begin
      failures++;
      $display("FAIL reset_mid_recover: mosi %h csb %0d want mosi %h csb %0d", oc, ocs, ec, ecs);
    end
  endtask

  initial begin
    test_reset();
    test_write(3'd0, 16'h00AA);
    test_write(3'd1, 16'h55AA);
    test_write(3'd7, 16'h00C3);
    test_read(3'd2);
    test_read(3'd3);
    test_read(3'd4);
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
